// File: rtl/zonas_pkg.sv
// Shared types and width helpers for the multi-zone lighting scheduler.
package zonas_pkg;

  typedef enum logic [1:0] {
    DESLIGADA = 2'd0,
    ESPERA    = 2'd1,
    LIGADA    = 2'd2
  } estado_zona_t;

  // Bits needed to hold the values 0..valor inclusive.
  function automatic int largura_contador(input int valor);
    return (valor < 1) ? 1 : $clog2(valor + 1);
  endfunction

  // Bits needed to index n items, never less than one.
  function automatic int largura_indice(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/zona_timer.sv
// One zone: DESLIGADA/ESPERA/LIGADA state plus the switch-off countdown.
module zona_timer
  import zonas_pkg::*;
#(
  parameter int TEMPO_ON = 30000,
  parameter int CNT_W    = largura_contador(TEMPO_ON)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         pedido,
  input  logic         grant,
  output estado_zona_t estado,
  output logic         fim
);

  localparam logic [CNT_W-1:0] CARGA = CNT_W'(TEMPO_ON);

  estado_zona_t     estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    fim      = 1'b0;
    unique case (estado_q)
      DESLIGADA: begin
        if (pedido) estado_d = ESPERA;
      end
      ESPERA: begin
        // A dropped request beats a grant arriving in the same cycle.
        if (!pedido) begin
          estado_d = DESLIGADA;
        end else if (grant) begin
          estado_d = LIGADA;
          cnt_d    = CARGA;
        end
      end
      LIGADA: begin
        if (pedido) begin
          cnt_d = CARGA;
        end else if (tick && (cnt_q != '0)) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            estado_d = DESLIGADA;
            fim      = 1'b1;
          end
        end
      end
      default: begin
        estado_d = DESLIGADA;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= DESLIGADA;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
    end
  end

  assign estado = estado_q;

endmodule

// File: rtl/escalonador_zonas.sv
// Shares MAX_ATIVAS lamp-driver slots among N_ZONAS presence zones with
// round-robin granting and a per-zone switch-off delay of TEMPO_ON ticks.
module escalonador_zonas
  import zonas_pkg::*;
#(
  parameter int N_ZONAS    = 4,
  parameter int MAX_ATIVAS = 2,
  parameter int TEMPO_ON   = 30000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tick,
  input  logic [N_ZONAS-1:0]                pedido,
  output logic [N_ZONAS-1:0]                saida,
  output logic [N_ZONAS-1:0]                espera,
  output logic [$clog2(MAX_ATIVAS+1)-1:0]   n_ativas,
  output logic                              ocupado
);

  localparam int NA_W  = $clog2(MAX_ATIVAS + 1);
  localparam int PTR_W = largura_indice(N_ZONAS);
  localparam logic [NA_W-1:0] LIMITE = NA_W'(MAX_ATIVAS);

  if (N_ZONAS < 2 || N_ZONAS > 16) begin : g_chk_zonas
    $error("escalonador_zonas: N_ZONAS must be within 2..16");
  end
  if (MAX_ATIVAS < 1 || MAX_ATIVAS > N_ZONAS) begin : g_chk_ativas
    $error("escalonador_zonas: MAX_ATIVAS must be within 1..N_ZONAS");
  end
  if (TEMPO_ON < 1) begin : g_chk_tempo
    $error("escalonador_zonas: TEMPO_ON must be at least 1");
  end

  estado_zona_t        estados [N_ZONAS];
  logic [N_ZONAS-1:0]  fim;
  logic [N_ZONAS-1:0]  grant;
  logic [N_ZONAS-1:0]  candidatos;
  logic [PTR_W-1:0]    ptr, ptr_d;
  logic [NA_W-1:0]     n_prox;

  for (genvar i = 0; i < N_ZONAS; i++) begin : g_zona
    zona_timer #(
      .TEMPO_ON (TEMPO_ON)
    ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .pedido (pedido[i]),
      .grant  (grant[i]),
      .estado (estados[i]),
      .fim    (fim[i])
    );
  end

  always_comb begin
    saida  = '0;
    espera = '0;
    for (int i = 0; i < N_ZONAS; i++) begin
      saida[i]  = (estados[i] == LIGADA);
      espera[i] = (estados[i] == ESPERA);
    end
  end

  // Only zones still requesting compete, so a cancel never consumes a grant.
  assign candidatos = espera & pedido;

  always_comb begin
    int  idx;
    logic achou;
    idx   = 0;
    achou = 1'b0;
    grant = '0;
    ptr_d = ptr;
    if (n_ativas < LIMITE) begin
      for (int k = 0; k < N_ZONAS; k++) begin
        idx = (int'(ptr) + k) % N_ZONAS;
        if (!achou && candidatos[idx]) begin
          achou      = 1'b1;
          grant[idx] = 1'b1;
          ptr_d      = PTR_W'((idx + 1) % N_ZONAS);
        end
      end
    end
  end

  // Several zones may expire on the same tick while one new zone is granted.
  always_comb begin
    n_prox = n_ativas;
    if (|grant) n_prox = n_prox + NA_W'(1);
    for (int i = 0; i < N_ZONAS; i++) begin
      if (fim[i]) n_prox = n_prox - NA_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      n_ativas <= '0;
    end else begin
      ptr      <= ptr_d;
      n_ativas <= n_prox;
    end
  end

  assign ocupado = (n_ativas == LIMITE);

endmodule

// File: tb/tb_escalonador_zonas.sv
// Directed scenarios followed by randomized traffic, checked against a zone-level model.
module tb_escalonador_zonas;

  localparam int N    = 4;
  localparam int MAXA = 2;
  localparam int T    = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick = 1'b0;
  logic [N-1:0] pedido = '0;
  logic [N-1:0] saida, espera;
  logic [1:0]   n_ativas;
  logic         ocupado;

  always #5 clk = ~clk;

  escalonador_zonas #(
    .N_ZONAS    (N),
    .MAX_ATIVAS (MAXA),
    .TEMPO_ON   (T)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .pedido   (pedido),
    .saida    (saida),
    .espera   (espera),
    .n_ativas (n_ativas),
    .ocupado  (ocupado)
  );

  int total  = 0;
  int passou = 0;
  int falhas = 0;
  int fase   = 0;

  // Reference model: 0 = off, 1 = waiting, 2 = lit; rem = ticks left before switch-off.
  int m_st  [N];
  int m_rem [N];
  int m_ptr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    total++;
    assert (obs === esp) passou++;
    else begin
      falhas++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, esp);
    end
  endtask

  task automatic modelo(input logic [N-1:0] p, input logic t, input logic r);
    int acesas, venc, z;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_st[i]  = 0;
        m_rem[i] = 0;
      end
      m_ptr = 0;
      return;
    end
    acesas = 0;
    for (int i = 0; i < N; i++) if (m_st[i] == 2) acesas++;
    venc = -1;
    if (acesas < MAXA) begin
      for (int k = 0; k < N; k++) begin
        z = (m_ptr + k) % N;
        if (venc < 0 && m_st[z] == 1 && p[z]) venc = z;
      end
    end
    for (int i = 0; i < N; i++) begin
      case (m_st[i])
        0: if (p[i]) m_st[i] = 1;
        1: begin
          if (!p[i]) m_st[i] = 0;
          else if (i == venc) begin
            m_st[i]  = 2;
            m_rem[i] = T;
          end
        end
        default: begin
          if (p[i]) m_rem[i] = T;
          else if (t && m_rem[i] > 0) begin
            m_rem[i] = m_rem[i] - 1;
            if (m_rem[i] == 0) m_st[i] = 0;
          end
        end
      endcase
    end
    if (venc >= 0) m_ptr = (venc + 1) % N;
  endtask

  task automatic ciclo(input logic [N-1:0] p, input logic t, input logic r);
    logic [N-1:0] es, ee;
    int na;
    pedido = p;
    tick   = t;
    rst    = r;
    @(posedge clk);
    modelo(p, t, r);
    #1;
    es = '0;
    ee = '0;
    na = 0;
    for (int i = 0; i < N; i++) begin
      es[i] = (m_st[i] == 2);
      ee[i] = (m_st[i] == 1);
      if (m_st[i] == 2) na++;
    end
    chk("saida_modelo",    32'(saida),    32'(es));
    chk("espera_modelo",   32'(espera),   32'(ee));
    chk("n_ativas_modelo", 32'(n_ativas), 32'(na));
    chk("ocupado_modelo",  32'(ocupado),  32'(na == MAXA));
  endtask

  // Directed steps: tick every 4th clock.
  task automatic passo(input logic [N-1:0] p);
    ciclo(p, fase == 3, 1'b0);
    fase = (fase + 1) % 4;
  endtask

  task automatic reinicia(input logic [N-1:0] p);
    ciclo(p, fase == 3, 1'b1);
    fase = (fase + 1) % 4;
  endtask

  task automatic conta_ticks(input logic [N-1:0] p, input int n);
    int vistos, guarda;
    vistos = 0;
    guarda = 0;
    while (vistos < n && guarda < 200) begin
      passo(p);
      if (tick) vistos++;
      guarda++;
    end
    chk("ticks_dentro_do_limite", 32'(vistos), 32'(n));
  endtask

  initial begin
    logic [N-1:0] p;
    logic         t, r;

    // Reset state
    reinicia(4'b0000);
    reinicia(4'b0000);
    chk("rst_saida",    32'(saida),    32'h0);
    chk("rst_espera",   32'(espera),   32'h0);
    chk("rst_n_ativas", 32'(n_ativas), 32'h0);
    chk("rst_ocupado",  32'(ocupado),  32'h0);

    // Single zone: request-to-lamp latency and switch-off on the 5th quiet tick
    passo(4'b0001);
    chk("unico_espera", 32'(espera), 32'b0001);
    chk("unico_saida0", 32'(saida),  32'b0000);
    passo(4'b0001);
    chk("unico_saida1", 32'(saida),  32'b0001);
    chk("unico_n",      32'(n_ativas), 32'd1);
    conta_ticks(4'b0000, 4);
    chk("unico_tick4", 32'(saida[0]), 32'd1);
    conta_ticks(4'b0000, 1);
    chk("unico_tick5", 32'(saida[0]), 32'd0);
    chk("unico_n_fim", 32'(n_ativas), 32'd0);

    // Retrigger at the 4th tick of the countdown
    passo(4'b0001);
    passo(4'b0001);
    conta_ticks(4'b0000, 3);
    while (fase != 3) passo(4'b0000);
    passo(4'b0001);
    chk("retrig_tick4", 32'(saida[0]), 32'd1);
    conta_ticks(4'b0000, 4);
    chk("retrig_mais4", 32'(saida[0]), 32'd1);
    conta_ticks(4'b0000, 1);
    chk("retrig_mais5", 32'(saida[0]), 32'd0);

    // Saturation from idle with the pointer back at zone 0
    reinicia(4'b0000);
    passo(4'b1111);
    chk("sat_espera0", 32'(espera), 32'b1111);
    passo(4'b1111);
    chk("sat_saida1", 32'(saida), 32'b0001);
    passo(4'b1111);
    chk("sat_saida2",  32'(saida),   32'b0011);
    chk("sat_espera2", 32'(espera),  32'b1100);
    chk("sat_ocupado", 32'(ocupado), 32'd1);
    passo(4'b1111);
    chk("sat_mantem", 32'(saida), 32'b0011);

    // Release of zone 0: zone 2 granted one cycle after the expiry edge
    conta_ticks(4'b1110, 5);
    chk("lib_expira", 32'(saida),  32'b0010);
    chk("lib_espera", 32'(espera), 32'b1100);
    passo(4'b1110);
    chk("lib_rr_saida",  32'(saida),  32'b0110);
    chk("lib_rr_espera", 32'(espera), 32'b1000);

    // Cancel race: zone 3 drops its request as a slot becomes grantable
    conta_ticks(4'b1100, 5);
    chk("canc_livre", 32'(saida), 32'b0100);
    passo(4'b0100);
    chk("canc_saida",  32'(saida),    32'b0100);
    chk("canc_espera", 32'(espera),   32'b0000);
    chk("canc_n",      32'(n_ativas), 32'd1);
    // Pointer still at 3: zone 3 must beat zone 0
    passo(4'b1101);
    chk("canc_ptr_espera", 32'(espera), 32'b1001);
    passo(4'b1101);
    chk("canc_ptr_saida", 32'(saida),  32'b1100);
    chk("canc_ptr_wait",  32'(espera), 32'b0001);

    // Reset mid-operation with two lamps lit and requests held high
    reinicia(4'b0000);
    passo(4'b0011);
    passo(4'b0011);
    passo(4'b0011);
    chk("rstm_antes", 32'(saida), 32'b0011);
    reinicia(4'b0011);
    chk("rstm_saida",  32'(saida),    32'h0);
    chk("rstm_espera", 32'(espera),   32'h0);
    chk("rstm_n",      32'(n_ativas), 32'h0);
    passo(4'b0011);
    chk("rstm_reentra", 32'(espera), 32'b0011);

    // Randomized traffic with sparse resets
    p = 4'b0011;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) p[i] = ~p[i];
      end
      t = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 299) == 0);
      ciclo(p, t, r);
    end

    $display("%0d/%0d checks passed", passou, total);
    $finish;
  end

endmodule
